// File: rtl/simd_wave_scheduler.sv
// simd_wave_scheduler: multi-wavefront issue controller.
// Holds NUM_WAVE_SLOTS resident waves, picks a READY wave round-robin, issues it
// over TOTAL_WAVE_CYCLES lane-group beats, then parks it until execute completes it.
// Optional macro SIMD_WAVE_SCHED_PERF_EN adds issue-beat and stall counters.
module simd_wave_scheduler #(
   parameter int NUM_WAVE_SLOTS         = 4,
   parameter int LANE_WIDTH             = 16,
   parameter int WAVE_SIZE              = 32,
   parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
   localparam int TOTAL_WAVE_CYCLES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH,
   localparam int SW = $clog2(NUM_WAVE_SLOTS),
   localparam int CW = (TOTAL_WAVE_CYCLES > 1) ? $clog2(TOTAL_WAVE_CYCLES) : 1,
   localparam int TW = $clog2(WAVE_SIZE) + 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              dispatch_valid,
   output logic                              dispatch_ready,
   input  logic [31:0]                       dispatch_wave_id,
   input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] dispatch_pc,
   input  logic [TW-1:0]                     dispatch_active_threads,
   output logic                              issue_valid,
   input  logic                              issue_ready,
   output logic [SW-1:0]                     issue_slot,
   output logic [31:0]                       issue_wave_id,
   output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] issue_pc,
   output logic [CW-1:0]                     issue_wave_cycle,
   output logic [LANE_WIDTH-1:0]             issue_lane_mask,
   input  logic                              complete_valid,
   input  logic [SW-1:0]                     complete_slot,
   input  logic                              complete_done,
   input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] complete_next_pc,
   output logic                              wave_done_valid,
   output logic [31:0]                       wave_done_id,
   output logic                              all_idle,
   output logic                              protocol_err
`ifdef SIMD_WAVE_SCHED_PERF_EN
   ,
   output logic [31:0]                       perf_issue_beats,
   output logic [31:0]                       perf_stall_cycles
`endif
);

   localparam int N  = NUM_WAVE_SLOTS;
   localparam int PW = PROGRAM_MEM_ADDR_WIDTH;
   localparam logic [CW-1:0] LAST_CYCLE = CW'(TOTAL_WAVE_CYCLES - 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_READY, ST_ISSUING, ST_WAITING} slot_state_t;

   slot_state_t   r_state [N];
   slot_state_t   w_state_next [N];
   logic [31:0]   r_wave_id [N];
   logic [31:0]   w_wave_id_next [N];
   logic [PW-1:0] r_pc [N];
   logic [PW-1:0] w_pc_next [N];
   logic [TW-1:0] r_threads [N];
   logic [TW-1:0] w_threads_next [N];

   logic [SW-1:0] r_rr_ptr, w_rr_ptr_next;
   logic          r_busy, w_busy_next;
   logic [SW-1:0] r_issue_slot, w_issue_slot_next;
   logic [CW-1:0] r_wave_cycle, w_wave_cycle_next;
   logic          r_protocol_err, w_protocol_err_next;
   logic          r_done_valid, w_done_valid_next;
   logic [31:0]   r_done_id, w_done_id_next;

   logic          w_any_empty;
   logic [SW-1:0] w_alloc_slot;
   logic          w_sel_found;
   logic [SW-1:0] w_sel_slot;
   logic          w_issue_fire;
   logic          w_complete_ok;
   logic [31:0]   w_beat_base;
   logic [TW-1:0] w_issue_threads;

   // Lowest-index EMPTY slot receives the next dispatched wave
   always_comb begin
      w_any_empty  = 1'b0;
      w_alloc_slot = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (r_state[k] == ST_EMPTY) begin
            w_any_empty  = 1'b1;
            w_alloc_slot = SW'(k);
         end
      end
   end

   // Round-robin search: first READY slot at or after the pointer, wrapping
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_slot  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (r_state[r_rr_ptr + SW'(k)] == ST_READY) begin
            w_sel_found = 1'b1;
            w_sel_slot  = r_rr_ptr + SW'(k);
         end
      end
   end

   assign dispatch_ready   = rst & enable & w_any_empty;
   assign issue_valid      = r_busy & enable;
   assign w_issue_fire     = issue_valid & issue_ready;
   assign issue_slot       = r_issue_slot;
   assign issue_wave_id    = r_wave_id[r_issue_slot];
   assign issue_pc         = r_pc[r_issue_slot];
   assign issue_wave_cycle = r_wave_cycle;
   assign w_issue_threads  = r_threads[r_issue_slot];
   assign w_beat_base      = 32'(r_wave_cycle) * 32'(LANE_WIDTH);
   assign w_complete_ok    = complete_valid & (r_state[complete_slot] == ST_WAITING);
   assign wave_done_valid  = r_done_valid;
   assign wave_done_id     = r_done_id;
   assign protocol_err     = r_protocol_err;

   // Lane i live iff its global thread index is below the wave's active count
   genvar gi;
   generate
      for (gi = 0; gi < LANE_WIDTH; gi++) begin : g_lane
         assign issue_lane_mask[gi] = (w_beat_base + 32'(gi)) < 32'(w_issue_threads);
      end
   endgenerate

   // Idle means no slot holds a wave
   always_comb begin
      all_idle = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (r_state[k] != ST_EMPTY) all_idle = 1'b0;
      end
   end

   // Next-state: dispatch, selection, issue and completion touch disjoint slot states
   always_comb begin
      w_state_next        = r_state;
      w_wave_id_next      = r_wave_id;
      w_pc_next           = r_pc;
      w_threads_next      = r_threads;
      w_rr_ptr_next       = r_rr_ptr;
      w_busy_next         = r_busy;
      w_issue_slot_next   = r_issue_slot;
      w_wave_cycle_next   = r_wave_cycle;
      w_protocol_err_next = r_protocol_err;
      w_done_valid_next   = 1'b0;
      w_done_id_next      = r_done_id;

      if (dispatch_valid && dispatch_ready) begin
         w_state_next[w_alloc_slot]   = ST_READY;
         w_wave_id_next[w_alloc_slot] = dispatch_wave_id;
         w_pc_next[w_alloc_slot]      = dispatch_pc;
         w_threads_next[w_alloc_slot] = dispatch_active_threads;
      end

      if (!r_busy && enable && w_sel_found) begin
         w_state_next[w_sel_slot] = ST_ISSUING;
         w_busy_next              = 1'b1;
         w_issue_slot_next        = w_sel_slot;
         w_wave_cycle_next        = '0;
         w_rr_ptr_next            = w_sel_slot + SW'(1);
      end

      if (w_issue_fire) begin
         if (r_wave_cycle == LAST_CYCLE) begin
            w_state_next[r_issue_slot] = ST_WAITING;
            w_busy_next                = 1'b0;
            w_wave_cycle_next          = '0;
         end else begin
            w_wave_cycle_next = r_wave_cycle + CW'(1);
         end
      end

      if (w_complete_ok) begin
         if (complete_done) begin
            w_state_next[complete_slot] = ST_EMPTY;
            w_done_valid_next           = 1'b1;
            w_done_id_next              = r_wave_id[complete_slot];
         end else begin
            w_state_next[complete_slot] = ST_READY;
            w_pc_next[complete_slot]    = complete_next_pc;
         end
      end else if (complete_valid) begin
         w_protocol_err_next = 1'b1;
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            r_state[k]   <= ST_EMPTY;
            r_wave_id[k] <= '0;
            r_pc[k]      <= '0;
            r_threads[k] <= '0;
         end
         r_rr_ptr       <= '0;
         r_busy         <= 1'b0;
         r_issue_slot   <= '0;
         r_wave_cycle   <= '0;
         r_protocol_err <= 1'b0;
         r_done_valid   <= 1'b0;
         r_done_id      <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            r_state[k]   <= w_state_next[k];
            r_wave_id[k] <= w_wave_id_next[k];
            r_pc[k]      <= w_pc_next[k];
            r_threads[k] <= w_threads_next[k];
         end
         r_rr_ptr       <= w_rr_ptr_next;
         r_busy         <= w_busy_next;
         r_issue_slot   <= w_issue_slot_next;
         r_wave_cycle   <= w_wave_cycle_next;
         r_protocol_err <= w_protocol_err_next;
         r_done_valid   <= w_done_valid_next;
         r_done_id      <= w_done_id_next;
      end
   end

`ifdef SIMD_WAVE_SCHED_PERF_EN
   logic [31:0] r_perf_issue_beats;
   logic [31:0] r_perf_stall_cycles;

   // Saturating counters of accepted beats and back-pressured beats
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_issue_beats  <= '0;
         r_perf_stall_cycles <= '0;
      end else begin
         if (w_issue_fire && (r_perf_issue_beats != 32'hFFFF_FFFF))
            r_perf_issue_beats <= r_perf_issue_beats + 32'd1;
         if (issue_valid && !issue_ready && (r_perf_stall_cycles != 32'hFFFF_FFFF))
            r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
   end

   assign perf_issue_beats  = r_perf_issue_beats;
   assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_simd_wave_scheduler.sv
// Testbench for simd_wave_scheduler: directed stimulus, a slot-level reference
// model of the scheduling rules, and a per-cycle output comparison.
module tb_simd_wave_scheduler;
   localparam int N   = 4;
   localparam int LW  = 16;
   localparam int PW  = 32;
   localparam int TWC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          dispatch_valid;
   logic          dispatch_ready;
   logic [31:0]   dispatch_wave_id;
   logic [PW-1:0] dispatch_pc;
   logic [5:0]    dispatch_active_threads;
   logic          issue_valid;
   logic          issue_ready;
   logic [1:0]    issue_slot;
   logic [31:0]   issue_wave_id;
   logic [PW-1:0] issue_pc;
   logic [0:0]    issue_wave_cycle;
   logic [15:0]   issue_lane_mask;
   logic          complete_valid;
   logic [1:0]    complete_slot;
   logic          complete_done;
   logic [PW-1:0] complete_next_pc;
   logic          wave_done_valid;
   logic [31:0]   wave_done_id;
   logic          all_idle;
   logic          protocol_err;
`ifdef SIMD_WAVE_SCHED_PERF_EN
   logic [31:0]   perf_issue_beats;
   logic [31:0]   perf_stall_cycles;
`endif

   simd_wave_scheduler dut (
      .clk(clk), .rst(rst), .enable(enable),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_wave_id(dispatch_wave_id), .dispatch_pc(dispatch_pc),
      .dispatch_active_threads(dispatch_active_threads),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_slot(issue_slot),
      .issue_wave_id(issue_wave_id), .issue_pc(issue_pc),
      .issue_wave_cycle(issue_wave_cycle), .issue_lane_mask(issue_lane_mask),
      .complete_valid(complete_valid), .complete_slot(complete_slot),
      .complete_done(complete_done), .complete_next_pc(complete_next_pc),
      .wave_done_valid(wave_done_valid), .wave_done_id(wave_done_id),
      .all_idle(all_idle), .protocol_err(protocol_err)
`ifdef SIMD_WAVE_SCHED_PERF_EN
      , .perf_issue_beats(perf_issue_beats), .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, exp, $time);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL %s: wait expired @%0t", name, $time);
   endtask

   // ---------------- reference model (0=empty 1=ready 2=issuing 3=waiting) -------------
   int          m_state [N] = '{default: 0};
   logic [31:0] m_id    [N] = '{default: 0};
   logic [31:0] m_pc    [N] = '{default: 0};
   int          m_thr   [N] = '{default: 0};
   int          m_rr  = 0;
   int          m_isl = -1;
   int          m_cyc = 0;
   logic        m_err = 1'b0;
   logic        m_dv  = 1'b0;
   logic [31:0] m_did = '0;

   function automatic bit has_empty(input int st [N]);
      for (int k = 0; k < N; k++) if (st[k] == 0) return 1'b1;
      return 1'b0;
   endfunction

   // Threads still remaining at this beat decide how many low lanes are live
   function automatic logic [15:0] lane_mask(input int thr, input int cyc);
      int rem;
      rem = thr - cyc * LW;
      if (rem >= LW) return 16'hFFFF;
      if (rem <= 0)  return 16'h0000;
      return 16'((32'd1 << rem) - 32'd1);
   endfunction

   always @(posedge clk or negedge rst) begin : model
      int o [N];
      int nisl, ncyc, nrr;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            m_state[k] = 0; m_id[k] = 0; m_pc[k] = 0; m_thr[k] = 0;
         end
         m_rr = 0; m_isl = -1; m_cyc = 0; m_err = 0; m_dv = 0; m_did = 0;
      end else begin
         o = m_state; nisl = m_isl; ncyc = m_cyc; nrr = m_rr;
         if (dispatch_valid && enable && has_empty(o)) begin
            for (int k = 0; k < N; k++) begin
               if (o[k] == 0) begin
                  m_state[k] = 1; m_id[k] = dispatch_wave_id;
                  m_pc[k] = dispatch_pc; m_thr[k] = int'(dispatch_active_threads);
                  break;
               end
            end
         end
         if (m_isl >= 0 && enable && issue_ready) begin
            if (m_cyc == TWC - 1) begin
               m_state[m_isl] = 3; nisl = -1; ncyc = 0;
            end else ncyc = m_cyc + 1;
         end
         if (m_isl < 0 && enable) begin
            for (int k = 0; k < N; k++) begin
               if (o[(m_rr + k) % N] == 1) begin
                  m_state[(m_rr + k) % N] = 2;
                  nisl = (m_rr + k) % N; ncyc = 0; nrr = (nisl + 1) % N;
                  break;
               end
            end
         end
         m_dv = 1'b0;
         if (complete_valid) begin
            if (o[complete_slot] == 3) begin
               if (complete_done) begin
                  m_state[complete_slot] = 0; m_dv = 1'b1; m_did = m_id[complete_slot];
               end else begin
                  m_state[complete_slot] = 1; m_pc[complete_slot] = complete_next_pc;
               end
            end else m_err = 1'b1;
         end
         m_isl = nisl; m_cyc = ncyc; m_rr = nrr;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      chk("dispatch_ready", dispatch_ready, rst && enable && has_empty(m_state));
      chk("issue_valid", issue_valid, (m_isl >= 0) && enable);
      if (m_isl >= 0 && enable) begin
         chk("issue_slot", issue_slot, 32'(m_isl));
         chk("issue_wave_id", issue_wave_id, m_id[m_isl]);
         chk("issue_pc", issue_pc, m_pc[m_isl]);
         chk("issue_wave_cycle", issue_wave_cycle, 32'(m_cyc));
         chk("issue_lane_mask", issue_lane_mask, lane_mask(m_thr[m_isl], m_cyc));
      end
      chk("all_idle", all_idle, (m_state[0] == 0 && m_state[1] == 0 && m_state[2] == 0 && m_state[3] == 0));
      chk("protocol_err", protocol_err, m_err);
      chk("wave_done_valid", wave_done_valid, m_dv);
      chk("wave_done_id", wave_done_id, m_did);
   end

   // ---------------- stimulus tasks ----------------
   task automatic dispatch(input logic [31:0] id, input logic [31:0] pc, input int thr);
      bit ok = 1'b0;
      @(posedge clk); #1;
      dispatch_valid = 1'b1; dispatch_wave_id = id; dispatch_pc = pc;
      dispatch_active_threads = 6'(thr);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dispatch_ready) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("dispatch");
      else begin @(posedge clk); #1; end
      dispatch_valid = 1'b0;
      $display("dispatch id=%0d pc=0x%0h threads=%0d", id, pc, thr);
   endtask

   task automatic expect_beat(input int slot, input int cyc, input logic [31:0] id,
                              input logic [31:0] pc, input logic [15:0] mask);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (issue_valid && issue_slot == 2'(slot) && issue_wave_cycle == 1'(cyc)) begin
            ok = 1'b1; break;
         end
      end
      if (!ok) timeout("expect_beat");
      else begin
         chk("beat_wave_id", issue_wave_id, id);
         chk("beat_pc", issue_pc, pc);
         chk("beat_mask", issue_lane_mask, mask);
      end
      $display("beat slot=%0d cycle=%0d id=%0d pc=0x%0h mask=0x%04h", slot, cyc, issue_wave_id, issue_pc, issue_lane_mask);
   endtask

   task automatic complete(input int slot, input bit done, input logic [31:0] npc);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (m_state[slot] == 3) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("complete_wait");
      else begin
         complete_valid = 1'b1; complete_slot = 2'(slot);
         complete_done = done; complete_next_pc = npc;
         @(posedge clk); #1;
         complete_valid = 1'b0;
      end
      $display("complete slot=%0d done=%0d next_pc=0x%0h", slot, done, npc);
   endtask

   task automatic bad_complete(input int slot);
      @(posedge clk); #1;
      complete_valid = 1'b1; complete_slot = 2'(slot); complete_done = 1'b0;
      complete_next_pc = 32'hDEAD;
      @(posedge clk); #1;
      complete_valid = 1'b0;
      $display("illegal completion slot=%0d", slot);
   endtask

   task automatic wait_done(input logic [31:0] id);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (wave_done_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) timeout("wave_done");
      else chk("wave_done_id_lit", wave_done_id, id);
      $display("wave_done id=%0d", wave_done_id);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b0; enable = 1'b1; dispatch_valid = 1'b0; dispatch_wave_id = '0;
      dispatch_pc = '0; dispatch_active_threads = '0; issue_ready = 1'b1;
      complete_valid = 1'b0; complete_slot = '0; complete_done = 1'b0; complete_next_pc = '0;

      repeat (2) @(negedge clk);
      chk("reset_dispatch_ready", dispatch_ready, 0);
      chk("reset_issue_valid", issue_valid, 0);
      chk("reset_all_idle", all_idle, 1);
      chk("reset_protocol_err", protocol_err, 0);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("idle_dispatch_ready", dispatch_ready, 1);
      chk("idle_issue_valid", issue_valid, 0);
      @(posedge clk); #1 enable = 1'b0;
      @(negedge clk);
      chk("disabled_dispatch_ready", dispatch_ready, 0);
      enable = 1'b1;

      // Full wave, continue, then retire
      dispatch(32'd5, 32'h100, 32);
      expect_beat(0, 0, 32'd5, 32'h100, 16'hFFFF);
      expect_beat(0, 1, 32'd5, 32'h100, 16'hFFFF);
      complete(0, 1'b0, 32'h104);
      expect_beat(0, 0, 32'd5, 32'h104, 16'hFFFF);
      expect_beat(0, 1, 32'd5, 32'h104, 16'hFFFF);
      complete(0, 1'b1, 32'h0);
      wait_done(32'd5);

      // Partial and all-zero tail beats
      dispatch(32'd6, 32'h200, 20);
      expect_beat(0, 0, 32'd6, 32'h200, 16'hFFFF);
      expect_beat(0, 1, 32'd6, 32'h200, 16'h000F);
      complete(0, 1'b1, 32'h0);
      wait_done(32'd6);
      dispatch(32'd7, 32'h300, 8);
      expect_beat(0, 0, 32'd7, 32'h300, 16'h00FF);
      expect_beat(0, 1, 32'd7, 32'h300, 16'h0000);
      complete(0, 1'b1, 32'h0);
      wait_done(32'd7);

      // Fill all slots while issue is back-pressured, then round-robin order
      issue_ready = 1'b0;
      dispatch(32'd10, 32'h1000, 32);
      dispatch(32'd11, 32'h1100, 32);
      dispatch(32'd12, 32'h1200, 32);
      dispatch(32'd13, 32'h1300, 32);
      @(negedge clk);
      chk("full_dispatch_ready", dispatch_ready, 0);
      expect_beat(0, 0, 32'd10, 32'h1000, 16'hFFFF);
      issue_ready = 1'b1;
      expect_beat(0, 1, 32'd10, 32'h1000, 16'hFFFF);
      expect_beat(1, 0, 32'd11, 32'h1100, 16'hFFFF);
      expect_beat(2, 0, 32'd12, 32'h1200, 16'hFFFF);
      expect_beat(3, 0, 32'd13, 32'h1300, 16'hFFFF);
      complete(0, 1'b0, 32'h1010);
      expect_beat(0, 0, 32'd10, 32'h1010, 16'hFFFF);
      complete(1, 1'b0, 32'h1110);
      complete(2, 1'b1, 32'h0);
      wait_done(32'd12);
      chk("freed_dispatch_ready", dispatch_ready, 1);
      dispatch(32'd20, 32'h2000, 32);
      expect_beat(2, 0, 32'd20, 32'h2000, 16'hFFFF);

      // Back-pressure mid-wave holds outputs; illegal completion is sticky
      issue_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", issue_valid, 1);
         chk("stall_slot", issue_slot, 2);
         chk("stall_cycle", issue_wave_cycle, 0);
         chk("stall_pc", issue_pc, 32'h2000);
      end
      bad_complete(2);
      @(negedge clk);
      chk("protocol_err_set", protocol_err, 1);
      issue_ready = 1'b1;
      expect_beat(2, 1, 32'd20, 32'h2000, 16'hFFFF);

      // Reset asserted in the middle of an issue
      complete(3, 1'b0, 32'h3000);
      expect_beat(3, 0, 32'd13, 32'h3000, 16'hFFFF);
      chk("protocol_err_sticky", protocol_err, 1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_issue_valid", issue_valid, 0);
      chk("midrst_dispatch_ready", dispatch_ready, 0);
      chk("midrst_all_idle", all_idle, 1);
      chk("midrst_protocol_err", protocol_err, 0);
      chk("midrst_wave_done_valid", wave_done_valid, 0);
      chk("midrst_wave_done_id", wave_done_id, 0);
`ifdef SIMD_WAVE_SCHED_PERF_EN
      chk("midrst_perf_beats", perf_issue_beats, 0);
      chk("midrst_perf_stalls", perf_stall_cycles, 0);
`endif
      $display("reset asserted mid-issue");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_reset_dispatch_ready", dispatch_ready, 1);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
